// File: rtl/tetris_pkg.sv
// Shared board geometry, clear-FSM state encoding and a row-extract helper.
// Ports: none (package).
// Row r of a board vector occupies bits [COLS*r +: COLS]; row 0 is the top.
package tetris_pkg;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int BOARD_W   = ROWS * COLS;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } clear_state_t;

  function automatic logic [COLS-1:0] row_bits(input logic [BOARD_W-1:0]   board,
                                               input logic [ROW_IDX_W-1:0] r);
    return board[COLS*r +: COLS];
  endfunction

endpackage

// File: rtl/row_shift.sv
// Removes one row from a board and drops every row above it down by one.
// Ports: work_i (board), row_idx_i (row to remove) -> board_o (compacted board).
// Purely combinational; row 0 of the result is always empty.
module row_shift #(
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic [ROWS*COLS-1:0] work_i,
  input  logic [IDX_W-1:0]     row_idx_i,
  output logic [ROWS*COLS-1:0] board_o
);

  always_comb begin
    board_o = work_i;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        board_o[0 +: COLS] = '0;
      end else if (r <= int'(row_idx_i)) begin
        // Rows at or above the removed one take the content of the row above.
        board_o[COLS*r +: COLS] = work_i[COLS*(r-1) +: COLS];
      end
    end
  end

endmodule

// File: rtl/row_clearer.sv
// Snapshots the locked board, removes full rows bottom-up one per cycle, and
// reports the compacted board, lines cleared, saturating line total and overflow.
// Ports: clk/resetn, run (pause), start pulse, board_in -> busy, done, board_out,
// lines_cleared, lines_total, overflow.  Latency start->done = 1 + ROWS + lines.
module row_clearer #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int LINE_W     = 5,
  parameter int TOTAL_W    = 16,
  parameter int SPAWN_ROWS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] board_out,
  output logic [LINE_W-1:0]    lines_cleared,
  output logic [TOTAL_W-1:0]   lines_total,
  output logic                 overflow
);

  import tetris_pkg::*;

  localparam int BW    = ROWS * COLS;
  localparam int IDX_W = $clog2(ROWS);

  // The per-clear count can reach ROWS, so LINE_W must hold ROWS.
  if (LINE_W < $clog2(ROWS + 1)) begin : g_line_w_check
    $error("row_clearer: LINE_W too narrow to hold ROWS");
  end

  clear_state_t       state_q, state_d;
  logic [BW-1:0]      work_q, work_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [LINE_W-1:0]  lines_q, lines_d;
  logic [BW-1:0]      board_out_q, board_out_d;
  logic [LINE_W-1:0]  lines_cleared_q, lines_cleared_d;
  logic [TOTAL_W-1:0] lines_total_q, lines_total_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [BW-1:0]      shifted;
  logic               row_full;
  logic [TOTAL_W:0]   total_sum;

  row_shift #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .IDX_W (IDX_W)
  ) u_row_shift (
    .work_i    (work_q),
    .row_idx_i (row_idx_q),
    .board_o   (shifted)
  );

  assign row_full  = &work_q[COLS*row_idx_q +: COLS];
  // One extra bit catches the carry so the total can saturate instead of wrap.
  assign total_sum = {1'b0, lines_total_q} + (TOTAL_W+1)'(lines_q);

  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    row_idx_d       = row_idx_q;
    lines_d         = lines_q;
    board_out_d     = board_out_q;
    lines_cleared_d = lines_cleared_q;
    lines_total_d   = lines_total_q;
    overflow_d      = overflow_q;
    done_d          = 1'b0;

    // run = 0 freezes everything; done is a pulse so it simply stays low.
    if (run) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            work_d    = board_in;
            row_idx_d = IDX_W'(ROWS - 1);
            lines_d   = '0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            // Index stays put: the row that dropped in is checked next cycle.
            work_d  = shifted;
            lines_d = lines_q + LINE_W'(1);
          end else if (row_idx_q == '0) begin
            state_d = DONE;
          end else begin
            row_idx_d = row_idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          done_d          = 1'b1;
          board_out_d     = work_q;
          lines_cleared_d = lines_q;
          lines_total_d   = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
          overflow_d      = |work_q[SPAWN_ROWS*COLS-1:0];
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      work_q          <= '0;
      row_idx_q       <= '0;
      lines_q         <= '0;
      board_out_q     <= '0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
      overflow_q      <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      work_q          <= work_d;
      row_idx_q       <= row_idx_d;
      lines_q         <= lines_d;
      board_out_q     <= board_out_d;
      lines_cleared_q <= lines_cleared_d;
      lines_total_q   <= lines_total_d;
      overflow_q      <= overflow_d;
      done_q          <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign board_out     = board_out_q;
  assign lines_cleared = lines_cleared_q;
  assign lines_total   = lines_total_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_row_clearer.sv
// Self-checking bench for row_clearer: expected results are queued when each
// operation is started and compared when done pulses.
// Ports: none (top-level bench).
module tb_row_clearer;

  import tetris_pkg::*;

  localparam int W = BOARD_W;
  localparam logic [COLS-1:0] FULL = '1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          run;
  logic          start;
  logic [W-1:0]  board_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  board_out;
  logic [4:0]    lines_cleared;
  logic [15:0]   lines_total;
  logic          overflow;

  row_clearer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .LINE_W     (5),
    .TOTAL_W    (16),
    .SPAWN_ROWS (2)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .run           (run),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] board;
    logic [4:0]   lines;
    logic [15:0]  total;
    logic         ovf;
    int           lat;
    int           t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic [15:0] exp_total = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every done pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", W'(1), W'(0));
      end else begin
        cur = sb.pop_front();
        chk("latency", W'(cyc - cur.t0), W'(cur.lat));
        chk("board_out", board_out, cur.board);
        chk("lines_cleared", W'(lines_cleared), W'(cur.lines));
        chk("lines_total", W'(lines_total), W'(cur.total));
        chk("overflow", W'(overflow), W'(cur.ovf));
      end
    end
  end

  function automatic logic [W-1:0] put(input logic [W-1:0] b, input int r,
                                       input logic [COLS-1:0] v);
    logic [W-1:0] o;
    o = b;
    o[COLS*r +: COLS] = v;
    return o;
  endfunction

  // Reference: keep non-full rows in bottom-to-top order, pack them at the bottom.
  function automatic void model(input logic [W-1:0] b, output logic [W-1:0] o, output int n);
    int dst;
    dst = ROWS - 1;
    o   = '0;
    n   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_bits(b, ROW_IDX_W'(r)) == FULL) begin
        n++;
      end else begin
        o[COLS*dst +: COLS] = row_bits(b, ROW_IDX_W'(r));
        dst--;
      end
    end
  endfunction

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt == d0) begin
      chk("done_timeout", W'(0), W'(1));
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] b, input int pause_at, input int pause_len,
                        input int dup_at);
    logic [W-1:0] o;
    int           n;
    int           t;
    int           d0;
    exp_t         x;
    model(b, o, n);
    t         = int'(exp_total) + n;
    exp_total = (t > 65535) ? 16'hFFFF : 16'(t);
    x.board   = o;
    x.lines   = 5'(n);
    x.total   = exp_total;
    x.ovf     = |o[2*COLS-1:0];
    x.lat     = 1 + ROWS + n + pause_len;
    @(negedge clk);
    d0       = done_cnt;
    busy_cnt = 0;
    board_in = b;
    start    = 1'b1;
    x.t0     = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start    = 1'b0;
    board_in = ~b;  // must be ignored after the capture cycle
    if (pause_len > 0) begin
      repeat (pause_at) @(negedge clk);
      run = 1'b0;
      repeat (pause_len) @(negedge clk);
      run = 1'b1;
    end
    if (dup_at > 0) begin
      repeat (dup_at) @(negedge clk);
      start    = 1'b1;
      board_in = '1;
      @(negedge clk);
      start    = 1'b0;
    end
    wait_done(d0);
  endtask

  logic [W-1:0] b;
  logic [W-1:0] b4;
  int           d0;

  initial begin
    resetn   = 1'b0;
    run      = 1'b1;
    start    = 1'b0;
    board_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_board", board_out, W'(0));
    chk("rst_total", W'(lines_total), W'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Empty board: 21-cycle latency, busy for 21 cycles.
    run_op('0, 0, 0, 0);
    chk("empty_busy_cycles", W'(busy_cnt), W'(21));

    // Single bottom clear; the lone cell drops to row 19.
    b = put(put('0, 19, FULL), 18, 10'h001);
    run_op(b, 0, 0, 0);
    chk("t2_row19", W'(board_out[COLS*19 +: COLS]), W'(10'h001));
    chk("t2_total", W'(lines_total), W'(1));

    // Four stacked clears.
    b4 = '0;
    for (int r = 16; r < 20; r++) b4 = put(b4, r, FULL);
    b4 = put(b4, 15, 10'h2AA);
    run_op(b4, 0, 0, 0);
    chk("t3_row19", W'(board_out[COLS*19 +: COLS]), W'(10'h2AA));
    chk("t3_total", W'(lines_total), W'(5));

    // Non-adjacent clears plus a start while busy that must be ignored.
    b = put(put(put(put('0, 19, FULL), 17, FULL), 18, 10'h00F), 16, 10'h3C0);
    d0 = done_cnt;
    run_op(b, 0, 0, 5);
    repeat (30) @(negedge clk);
    chk("t4_one_done", W'(done_cnt - d0), W'(1));
    chk("t4_row18", W'(board_out[COLS*18 +: COLS]), W'(10'h3C0));

    // Overflow depends on the board after the clear.
    run_op(put(put('0, 1, 10'h001), 19, FULL), 0, 0, 0);
    chk("t5_no_ovf", W'(overflow), W'(0));
    run_op(put('0, 0, 10'h001), 0, 0, 0);
    chk("t5_ovf", W'(overflow), W'(1));

    // 50-cycle pause mid-scan delays done by exactly 50 cycles.
    run_op(b4, 5, 50, 0);

    // Reset at cycle 10 of a four-clear operation.
    @(negedge clk);
    board_in = b4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_board", board_out, W'(0));
    chk("mid_rst_lines", W'(lines_cleared), W'(0));
    chk("mid_rst_total", W'(lines_total), W'(0));
    chk("mid_rst_ovf", W'(overflow), W'(0));
    @(negedge clk);
    resetn    = 1'b1;
    exp_total = '0;
    d0        = done_cnt;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", W'(done_cnt - d0), W'(0));

    // Random boards after recovery, roughly one row in four full.
    for (int i = 0; i < 6; i++) begin
      b = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 3) == 0) b = put(b, r, FULL);
        else                           b = put(b, r, COLS'($urandom));
      end
      run_op(b, 0, 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
